// File: rtl/mc_fetch_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core.
// It owns the PC and the instruction register and drives Moore control strobes to the datapath.
module mc_fetch_sequencer #(
  parameter int              PC_W              = 5,
  parameter logic [PC_W-1:0] RESET_PC          = '0,
  parameter bit              HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     instruction,
  input  logic            ne,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            ir_load,
  output logic            alu_en,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            rf_we,
  output logic            retire,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_J   = 4'b1111;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     ir_reg, ir_next;

  logic [3:0]      opcode;
  logic            is_alu, is_lw, is_sw, is_bne, is_j, is_nop;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     imm_sext;
  logic [PC_W-1:0] bne_target;
  logic [PC_W-1:0] j_target;

  assign opcode = ir_reg[15:12];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_bne = (opcode == OP_BNE);
  assign is_j   = (opcode == OP_J);
  assign is_nop = !(is_alu || is_lw || is_sw || is_bne || is_j);

  // All PC arithmetic is done at PC_W bits so it wraps modulo the ROM depth.
  assign pc_inc     = pc_reg + PC_W'(1);
  assign imm_sext   = {{12{ir_reg[3]}}, ir_reg[3:0]};
  assign bne_target = pc_inc + imm_sext[PC_W-1:0];
  assign j_target   = ir_reg[PC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // Next state and Moore outputs; inputs only steer state, never outputs.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rf_we      = 1'b0;
    retire     = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end

      S_FETCH: begin
        ir_load    = 1'b1;
        ir_next    = instruction;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        if (is_j) begin
          retire = 1'b1;
          if (HALT_ON_SELF_JUMP && (j_target == pc_reg)) begin
            state_next = S_HALT;
          end else begin
            pc_next    = j_target;
            state_next = S_FETCH;
          end
        end else if (is_nop) begin
          retire     = 1'b1;
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_en = 1'b1;
        if (is_bne) begin
          retire     = 1'b1;
          pc_next    = ne ? bne_target : pc_inc;
          state_next = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        if (is_sw) begin
          mem_wr     = 1'b1;
          retire     = 1'b1;
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end else begin
          mem_rd     = 1'b1;
          state_next = S_WB;
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        pc_next    = pc_inc;
        state_next = S_FETCH;
      end

      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end

      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign pc = pc_reg;
  assign ir = ir_reg;

endmodule

// File: tb/tb_mc_fetch_sequencer.sv
// Directed bench for mc_fetch_sequencer: runs a small ROM program and checks every cycle's strobes.
// Strobe vector order: {ir_load, alu_en, mem_rd, mem_wr, rf_we, retire, busy, halted}.
module tb_mc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instruction;
  logic        ne;
  logic [4:0]  pc;
  logic [15:0] ir;
  logic        ir_load, alu_en, mem_rd, mem_wr, rf_we, retire, busy, halted;

  logic [15:0] rom [0:31];
  int total;
  int bad;

  localparam logic [7:0] ST_IDLE = 8'b0000_0000;
  localparam logic [7:0] ST_F    = 8'b1000_0010;
  localparam logic [7:0] ST_D    = 8'b0000_0010;
  localparam logic [7:0] ST_DR   = 8'b0000_0110;
  localparam logic [7:0] ST_E    = 8'b0100_0010;
  localparam logic [7:0] ST_ER   = 8'b0100_0110;
  localparam logic [7:0] ST_MR   = 8'b0010_0010;
  localparam logic [7:0] ST_MW   = 8'b0001_0110;
  localparam logic [7:0] ST_W    = 8'b0000_1110;
  localparam logic [7:0] ST_H    = 8'b0000_0001;

  wire [7:0] strobes = {ir_load, alu_en, mem_rd, mem_wr, rf_we, retire, busy, halted};

  mc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction), .ne(ne),
    .pc(pc), .ir(ir), .ir_load(ir_load), .alu_en(alu_en), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .rf_we(rf_we), .retire(retire), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = rom[pc];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Check strobes and pc for the current cycle, then advance one cycle.
  task automatic cyc(input string tag, input logic [7:0] st, input logic [4:0] exp_pc);
    chk({tag, ".strobes"}, {8'h00, strobes}, {8'h00, st});
    chk({tag, ".pc"}, {11'h000, pc}, {11'h000, exp_pc});
    $display("step %s pc=%0d strobes=%b", tag, pc, strobes);
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h6000;  // sub
    rom[1]  = 16'hF007;  // j 7
    rom[7]  = 16'hE00D;  // bne, offset -3
    rom[5]  = 16'hF007;  // j 7
    rom[8]  = 16'hF002;  // j 2
    rom[2]  = 16'h8000;  // lw
    rom[3]  = 16'hA000;  // sw
    rom[4]  = 16'hF00B;  // j 11
    rom[11] = 16'hF01F;  // j 31
    rom[31] = 16'h0000;  // nop

    rst_n = 1'b0;
    start = 1'b0;
    ne    = 1'b0;
    step();
    step();
    chk("rst.strobes", {8'h00, strobes}, 16'h0000);
    chk("rst.pc", {11'h000, pc}, 16'h0000);
    chk("rst.ir", ir, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle", ST_IDLE, 5'd0);

    // sub at pc 0: 4 cycles
    start = 1'b1;
    step();
    start = 1'b0;
    cyc("sub.c1", ST_F, 5'd0);
    chk("sub.ir", ir, 16'h6000);
    cyc("sub.c2", ST_D, 5'd0);
    cyc("sub.c3", ST_E, 5'd0);
    cyc("sub.c4", ST_W, 5'd0);
    rom[0] = 16'h8000;  // lw for the reset-abort pass later

    // j 7 at pc 1
    cyc("j7.c1", ST_F, 5'd1);
    cyc("j7.c2", ST_DR, 5'd1);

    // bne taken at pc 7: 7+1-3 = 5
    ne = 1'b1;
    cyc("bneT.c1", ST_F, 5'd7);
    cyc("bneT.c2", ST_D, 5'd7);
    cyc("bneT.c3", ST_ER, 5'd7);
    ne = 1'b0;
    cyc("j7b.c1", ST_F, 5'd5);
    cyc("j7b.c2", ST_DR, 5'd5);

    // bne not taken at pc 7 -> 8
    cyc("bneN.c1", ST_F, 5'd7);
    cyc("bneN.c2", ST_D, 5'd7);
    cyc("bneN.c3", ST_ER, 5'd7);
    cyc("j2.c1", ST_F, 5'd8);
    cyc("j2.c2", ST_DR, 5'd8);

    // lw at pc 2: 5 cycles
    cyc("lw.c1", ST_F, 5'd2);
    chk("lw.ir", ir, 16'h8000);
    cyc("lw.c2", ST_D, 5'd2);
    cyc("lw.c3", ST_E, 5'd2);
    cyc("lw.c4", ST_MR, 5'd2);
    cyc("lw.c5", ST_W, 5'd2);

    // sw at pc 3: 4 cycles, no rf_we
    cyc("sw.c1", ST_F, 5'd3);
    cyc("sw.c2", ST_D, 5'd3);
    cyc("sw.c3", ST_E, 5'd3);
    cyc("sw.c4", ST_MW, 5'd3);

    // j 11, then j 31, then nop at 31 wraps to 0
    cyc("j11.c1", ST_F, 5'd4);
    cyc("j11.c2", ST_DR, 5'd4);
    cyc("j31.c1", ST_F, 5'd11);
    cyc("j31.c2", ST_DR, 5'd11);
    cyc("nop.c1", ST_F, 5'd31);
    chk("nop.ir", ir, 16'h0000);
    cyc("nop.c2", ST_DR, 5'd31);

    // lw at pc 0, aborted by reset during MEM
    cyc("lwR.c1", ST_F, 5'd0);
    cyc("lwR.c2", ST_D, 5'd0);
    cyc("lwR.c3", ST_E, 5'd0);
    chk("lwR.mem", {8'h00, strobes}, {8'h00, ST_MR});
    rst_n = 1'b0;
    #1;
    chk("abort.strobes", {8'h00, strobes}, 16'h0000);
    chk("abort.pc", {11'h000, pc}, 16'h0000);
    chk("abort.ir", ir, 16'h0000);
    step();
    rst_n = 1'b1;
    cyc("abort.idle1", ST_IDLE, 5'd0);
    cyc("abort.idle2", ST_IDLE, 5'd0);

    // j 31 from pc 0, then j-to-self at 31 halts
    rom[0]  = 16'hF01F;
    rom[31] = 16'hF01F;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc("jh.c1", ST_F, 5'd0);
    cyc("jh.c2", ST_DR, 5'd0);
    cyc("self.c1", ST_F, 5'd31);
    cyc("self.c2", ST_DR, 5'd31);
    start = 1'b1;
    for (int i = 0; i < 4; i++) cyc("halt", ST_H, 5'd31);
    chk("halt.ir", ir, 16'hF01F);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
